// File: rtl/qam_demapper_rx_if.sv
// qam_demapper_rx_if: sample-in / bits-out handshake bundle for qam_demapper_rx.
//   Upstream side  : mod_switch, i_in, q_in, valid_in, sop -> ready_out
//   Downstream side: bits_out, valid_out, data_idx, eof   <- ready_in
// master = the environment (source + sink), slave = the demapper.
interface qam_demapper_rx_if;
    logic               mod_switch;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic               valid_in;
    logic               sop;
    logic               ready_out;
    logic [3:0]         bits_out;
    logic               valid_out;
    logic               ready_in;
    logic [10:0]        data_idx;
    logic               eof;

    modport master (
        output mod_switch, i_in, q_in, valid_in, sop, ready_in,
        input  ready_out, bits_out, valid_out, data_idx, eof
    );

    modport slave (
        input  mod_switch, i_in, q_in, valid_in, sop, ready_in,
        output ready_out, bits_out, valid_out, data_idx, eof
    );
endinterface

// File: rtl/qam_demapper_rx.sv
// qam_demapper_rx: strips preamble and pilot carriers from an equalised I/Q
// frame and hard-slices each data carrier to QPSK (2b) or 16-QAM (4b) bits.
// Ports:
//   clk, res   clock, synchronous active-high reset
//   en         global enable; low freezes all state
//   bus        qam_demapper_rx_if.slave (samples in, bits out, valid/ready)
//   dist_acc, dist_valid   per-frame slicing-distance sum (DIST_ACC_EN only)
// Optional feature macro: DIST_ACC_EN.
module qam_demapper_rx #(
    parameter int unsigned LEVEL      = 8192,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned PREAMB_LEN = 128,
    parameter int unsigned PILOT_STEP = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    en,
    qam_demapper_rx_if.slave        bus
`ifdef DIST_ACC_EN
    ,
    output logic [23:0]             dist_acc,
    output logic                    dist_valid
`endif
);

    localparam int unsigned K_W    = $clog2(FRAME_LEN);
    localparam int unsigned P_W    = (PILOT_STEP > 1) ? $clog2(PILOT_STEP) : 1;
    localparam int unsigned D_W    = 11;
    // Last data carrier: final sample unless it lands on a pilot slot
    localparam int unsigned K_LAST =
        (((FRAME_LEN - 1 - PREAMB_LEN) % PILOT_STEP) != 0) ? FRAME_LEN - 1 : FRAME_LEN - 2;

    localparam logic signed [16:0] TWO_L     = 17'(2 * LEVEL);
    localparam logic signed [16:0] NEG_TWO_L = -TWO_L;

    typedef enum logic [0:0] {IDLE, FRAME} state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [P_W-1:0] p_q, p_d;
    logic [D_W-1:0] didx_q, didx_d;

    logic           valid_q;
    logic [3:0]     bits_q;
    logic [D_W-1:0] data_idx_q;
    logic           eof_q;

    logic           accept_c;
    logic           in_frame_c;
    logic [K_W-1:0] k_eff_c;
    logic [P_W-1:0] p_eff_c;
    logic [D_W-1:0] didx_eff_c;
    logic           is_data_c;
    logic           last_c;
    logic signed [16:0] i_x_c, q_x_c;
    logic [3:0]     bits_c;

    // Gray hard decision on one 16-QAM axis
    function automatic logic [1:0] slice_axis(input logic signed [16:0] v);
        logic [1:0] r;
        if (v < NEG_TWO_L)  r = 2'b00;
        else if (v[16])     r = 2'b01;
        else if (v < TWO_L) r = 2'b11;
        else                r = 2'b10;
        return r;
    endfunction

    assign bus.ready_out = en && (!valid_q || bus.ready_in);
    assign bus.valid_out = valid_q;
    assign bus.bits_out  = bits_q;
    assign bus.data_idx  = data_idx_q;
    assign bus.eof       = eof_q;

    // Frame position, pilot phase and data index; sop overrides the stored position
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        p_d        = p_q;
        didx_d     = didx_q;
        accept_c   = bus.valid_in && bus.ready_out;
        in_frame_c = bus.sop || (state_q == FRAME);
        k_eff_c    = bus.sop ? '0 : k_q;
        p_eff_c    = bus.sop ? '0 : p_q;
        didx_eff_c = bus.sop ? '0 : didx_q;
        is_data_c  = in_frame_c && (k_eff_c >= K_W'(PREAMB_LEN)) && (p_eff_c != '0);
        last_c     = (k_eff_c == K_W'(K_LAST));
        if (accept_c && in_frame_c) begin
            if (k_eff_c == K_W'(FRAME_LEN - 1)) begin
                state_d = IDLE;
                k_d     = '0;
            end else begin
                state_d = FRAME;
                k_d     = k_eff_c + K_W'(1);
            end
            // Pilot phase holds at 0 through the preamble, then wraps every PILOT_STEP
            if (k_eff_c >= K_W'(PREAMB_LEN))
                p_d = (p_eff_c == P_W'(PILOT_STEP - 1)) ? '0 : p_eff_c + P_W'(1);
            else
                p_d = '0;
            didx_d = is_data_c ? didx_eff_c + D_W'(1) : didx_eff_c;
        end
    end

    // Slicer; 17-bit sign extension keeps the +/-2*LEVEL thresholds representable
    always_comb begin
        i_x_c  = 17'(bus.i_in);
        q_x_c  = 17'(bus.q_in);
        bits_c = bus.mod_switch ? {slice_axis(i_x_c), slice_axis(q_x_c)}
                                : {2'b00, ~i_x_c[16], ~q_x_c[16]};
    end

    // FSM state and frame counters
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            k_q     <= '0;
            p_q     <= '0;
            didx_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            didx_q  <= didx_d;
        end
    end

    // Single output register; load and downstream take may coincide
    always_ff @(posedge clk) begin
        if (res) begin
            valid_q    <= 1'b0;
            bits_q     <= '0;
            data_idx_q <= '0;
            eof_q      <= 1'b0;
        end else if (en) begin
            if (accept_c && is_data_c) begin
                valid_q    <= 1'b1;
                bits_q     <= bits_c;
                data_idx_q <= didx_eff_c;
                eof_q      <= last_c;
            end else if (bus.ready_in) begin
                valid_q <= 1'b0;
                eof_q   <= 1'b0;
            end
        end
    end

`ifdef DIST_ACC_EN
    localparam int unsigned A_W = 24;
    localparam int unsigned E_W = 18;
    localparam logic signed [E_W-1:0] L1 = E_W'(LEVEL);
    localparam logic signed [E_W-1:0] L3 = E_W'(3 * LEVEL);

    logic [A_W-1:0] acc_q;
    logic [E_W-1:0] err_c;
    logic [A_W:0]   sum_c;
    logic [A_W-1:0] sat_c;
    logic [1:0]     ib_c, qb_c;

    // Ideal level for a 2-bit Gray code (QPSK reuses codes 01/11)
    function automatic logic signed [E_W-1:0] ideal_lvl(input logic [1:0] b);
        logic signed [E_W-1:0] r;
        case (b)
            2'b00:   r = -L3;
            2'b01:   r = -L1;
            2'b11:   r = L1;
            default: r = L3;
        endcase
        return r;
    endfunction

    function automatic logic [E_W-1:0] abs_err(input logic signed [16:0] v, input logic [1:0] b);
        logic signed [E_W-1:0] d;
        d = E_W'(v) - ideal_lvl(b);
        return d[E_W-1] ? E_W'(-d) : E_W'(d);
    endfunction

    always_comb begin
        ib_c  = bus.mod_switch ? bits_c[3:2] : {bits_c[1], 1'b1};
        qb_c  = bus.mod_switch ? bits_c[1:0] : {bits_c[0], 1'b1};
        err_c = abs_err(i_x_c, ib_c) + abs_err(q_x_c, qb_c);
        sum_c = {1'b0, (bus.sop ? '0 : acc_q)} + (A_W + 1)'(err_c);
        sat_c = sum_c[A_W] ? '1 : sum_c[A_W-1:0];
    end

    // Saturating distance accumulator, dumped and cleared at eof
    always_ff @(posedge clk) begin
        if (res) begin
            acc_q      <= '0;
            dist_acc   <= '0;
            dist_valid <= 1'b0;
        end else if (en) begin
            dist_valid <= 1'b0;
            if (accept_c && is_data_c) begin
                if (last_c) begin
                    dist_acc   <= sat_c;
                    dist_valid <= 1'b1;
                    acc_q      <= '0;
                end else begin
                    acc_q <= sat_c;
                end
            end else if (accept_c && bus.sop) begin
                acc_q <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qam_demapper_rx.sv
// tb_qam_demapper_rx: directed bench for qam_demapper_rx (default parameters).
module tb_qam_demapper_rx;

    logic clk;
    logic res;
    logic en;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [3:0]  bits;
        logic [10:0] idx;
        logic        eof;
    } beat_t;

    beat_t beats[$];

    qam_demapper_rx_if bus();

`ifdef DIST_ACC_EN
    logic [23:0] dist_acc;
    logic        dist_valid;
    int          dist_count;
    logic [23:0] dist_last;
`endif

    qam_demapper_rx dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .bus        (bus)
`ifdef DIST_ACC_EN
        ,
        .dist_acc   (dist_acc),
        .dist_valid (dist_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every beat the sink takes
    always @(negedge clk) begin
        if (!res && en && bus.valid_out && bus.ready_in)
            beats.push_back({bus.bits_out, bus.data_idx, bus.eof});
    end

`ifdef DIST_ACC_EN
    always @(negedge clk) begin
        if (!res && en && dist_valid) begin
            dist_count = dist_count + 1;
            dist_last  = dist_acc;
        end
    end
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input int q, input logic s, input logic m);
        int n;
        bus.i_in       = 16'(i);
        bus.q_in       = 16'(q);
        bus.sop        = s;
        bus.mod_switch = m;
        bus.valid_in   = 1'b1;
        #1;
        n = 0;
        while (!bus.ready_out && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.sop      = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        bus.sop      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int         thr_i [6];
    logic [1:0] thr_b [6];
    int         bad_bits;
    int         bad_idx;
    int         eof_cnt;

    initial begin
        checks         = 0;
        errors         = 0;
        res            = 1'b1;
        en             = 1'b1;
        bus.valid_in   = 1'b0;
        bus.sop        = 1'b0;
        bus.mod_switch = 1'b1;
        bus.i_in       = '0;
        bus.q_in       = '0;
        bus.ready_in   = 1'b1;
        thr_i = '{-16385, -16384, -1, 0, 16383, 16384};
        thr_b = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
`ifdef DIST_ACC_EN
        dist_count = 0;
        dist_last  = '0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        check("rst_bits", 32'(bus.bits_out), 32'd0);
        check("rst_idx", 32'(bus.data_idx), 32'd0);
        check("rst_eof", 32'(bus.eof), 32'd0);
        check("rst_ready", 32'(bus.ready_out), 32'd1);

        // Full 16-QAM frame, I=3L Q=-L
        beats.delete();
        for (int k = 0; k < 1024; k++) begin
            send(24576, -8192, k == 0, 1'b1);
            if (k == 128) check("pilot128_valid", 32'(bus.valid_out), 32'd0);
            if (k == 129) begin
                check("first_data_valid", 32'(bus.valid_out), 32'd1);
                check("first_data_idx", 32'(bus.data_idx), 32'd0);
                check("first_data_bits", 32'(bus.bits_out), 32'h9);
            end
        end
        idle(3);
        check("frame_beats", 32'(beats.size()), 32'd784);
        bad_bits = 0;
        bad_idx  = 0;
        eof_cnt  = 0;
        foreach (beats[n]) begin
            if (beats[n].bits != 4'b1001) bad_bits++;
            if (32'(beats[n].idx) != 32'(n)) bad_idx++;
            if (beats[n].eof) eof_cnt++;
        end
        check("frame_bad_bits", 32'(bad_bits), 32'd0);
        check("frame_bad_idx", 32'(bad_idx), 32'd0);
        check("frame_eof_cnt", 32'(eof_cnt), 32'd1);
        check("frame_last_eof", 32'(beats[beats.size()-1].eof), 32'd1);
        check("frame_last_idx", 32'(beats[beats.size()-1].idx), 32'd783);
`ifdef DIST_ACC_EN
        check("frame_dist_cnt", 32'(dist_count), 32'd1);
        check("frame_dist_acc", 32'(dist_last), 32'd0);
`endif

        // 16-QAM thresholds on I, Q=0 -> Q bits 11
        for (int k = 0; k < 129; k++) send(0, 0, k == 0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            send(thr_i[n], 0, 1'b0, 1'b1);
            check($sformatf("thr_%0d", thr_i[n]), 32'(bus.bits_out), 32'({thr_b[n], 2'b11}));
        end

        // QPSK (k=135 data, 136 pilot, 137 data)
        send(-5, 7, 1'b0, 1'b0);
        check("qpsk_neg_pos", 32'(bus.bits_out), 32'h1);
        send(0, 0, 1'b0, 1'b0);
        check("qpsk_pilot_valid", 32'(bus.valid_out), 32'd0);
        send(0, 0, 1'b0, 1'b0);
        check("qpsk_zero", 32'(bus.bits_out), 32'h3);
        check("qpsk_zero_idx", 32'(bus.data_idx), 32'd7);

        // Backpressure (k=138, 139)
        idle(1);
        beats.delete();
        bus.ready_in = 1'b0;
        send(24576, -24576, 1'b0, 1'b1);
        check("bp_first_bits", 32'(bus.bits_out), 32'h8);
        bus.i_in       = -16'sd24576;
        bus.q_in       = 16'sd24576;
        bus.mod_switch = 1'b1;
        bus.valid_in   = 1'b1;
        repeat (5) begin
            #1;
            check("bp_ready", 32'(bus.ready_out), 32'd0);
            check("bp_hold_bits", 32'(bus.bits_out), 32'h8);
            @(posedge clk);
            #1;
        end
        bus.ready_in = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.ready_out), 32'd1);
        @(posedge clk);
        #1;
        check("bp_next_bits", 32'(bus.bits_out), 32'h2);
        check("bp_next_idx", 32'(bus.data_idx), 32'd9);
        idle(2);
        check("bp_beats", 32'(beats.size()), 32'd2);
        check("bp_beat0", 32'({beats[0].bits, beats[0].idx}), 32'({4'h8, 11'd8}));
        check("bp_beat1", 32'({beats[1].bits, beats[1].idx}), 32'({4'h2, 11'd9}));

        // sop restart at k=500, then a complete frame of ideal points
        beats.delete();
`ifdef DIST_ACC_EN
        dist_count = 0;
`endif
        for (int k = 140; k < 500; k++) send(8192, 8192, 1'b0, 1'b1);
        for (int k = 0; k < 1024; k++) send(8192, 8192, k == 0, 1'b1);
        idle(3);
        check("rs_beats", 32'(beats.size()), 32'd1099);
        check("rs_old_last_idx", 32'(beats[314].idx), 32'd324);
        check("rs_new_first_idx", 32'(beats[315].idx), 32'd0);
        eof_cnt = 0;
        foreach (beats[n]) if (beats[n].eof) eof_cnt++;
        check("rs_eof_cnt", 32'(eof_cnt), 32'd1);
        check("rs_last", 32'({beats[1098].bits, beats[1098].idx, beats[1098].eof}),
              32'({4'hF, 11'd783, 1'b1}));
`ifdef DIST_ACC_EN
        check("rs_dist_cnt", 32'(dist_count), 32'd1);
        check("rs_dist_acc", 32'(dist_last), 32'd0);
`endif

        // en=0 freeze, then reset mid-frame while disabled
        for (int k = 0; k < 129; k++) send(0, 0, k == 0, 1'b1);
        send(-8192, 24576, 1'b0, 1'b1);
        check("mf_bits0", 32'(bus.bits_out), 32'h6);
        send(8192, -24576, 1'b0, 1'b1);
        en           = 1'b0;
        bus.valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("en0_ready", 32'(bus.ready_out), 32'd0);
        check("en0_hold", 32'({bus.valid_out, bus.bits_out, bus.data_idx}),
              32'({1'b1, 4'hC, 11'd1}));
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        check("mfrst_out", 32'({bus.valid_out, bus.bits_out, bus.data_idx, bus.eof}), 32'd0);
        en = 1'b1;
        beats.delete();
        for (int k = 0; k < 140; k++) send(24576 - k, 8192, 1'b0, 1'b1);
        idle(2);
        check("mfrst_no_out", 32'(beats.size()), 32'd0);
        check("mfrst_valid", 32'(bus.valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam_demapper_rx.md
Name: qam_demapper_rx

Overview:
- Receive-side counterpart of the transmit chain (bit ROM -> QAM mapper -> preamble/pilot insertion).
- Accepts a stream of equalised I/Q samples framed by sop.
- Discards the preamble and pilot subcarriers, then hard-slices each data subcarrier back to a 2-bit (QPSK) or 4-bit (16-QAM) symbol.
- Presents the bits downstream on a valid/ready handshake with one output register.

Parameters:
- LEVEL, 8192: unit amplitude; constellation points are ±1·LEVEL and ±3·LEVEL, and 16-QAM decision thresholds are 0 and ±2·LEVEL.
- FRAME_LEN, 1024: samples per frame, counted from the sop sample and including preamble and pilots.
- PREAMB_LEN, 128: leading samples of each frame that are preamble and are discarded.
- PILOT_STEP, 8: within the post-preamble region, every PILOT_STEP-th sample (offset 0) is a pilot and is discarded.

Ports:
- clk  in  1  clock
- res  in  1  synchronous active-high reset
- en  in  1  global enable; when low, all state is frozen
- mod_switch  in  1  0 = QPSK, 1 = 16-QAM; sampled per accepted sample
- i_in  in  16  signed I sample
- q_in  in  16  signed Q sample
- valid_in  in  1  upstream sample valid
- sop  in  1  qualifies valid_in; marks frame index 0
- ready_out  out  1  block can accept a sample
- bits_out  out  4  demapped bits, MSB pair from I, LSB pair from Q
- valid_out  out  1  bits_out valid
- ready_in  in  1  downstream ready
- data_idx  out  11  data-carrier index of bits_out (0-based within frame)
- eof  out  1  high with the last data carrier of a frame

Behaviour:
- Reset (res=1 at clk edge): valid_out=0, bits_out=0, data_idx=0, eof=0, frame counter=0, state=IDLE. Reset takes effect in the middle of a frame and regardless of en; any in-flight output is lost.
- ready_out = en && (!valid_out || ready_in). A sample is accepted when valid_in && ready_out.
- When en=0: no acceptance, and outputs hold their values.
- State machine:
  - IDLE: accepted samples without sop are dropped. An accepted sample with sop -> frame index 0, state FRAME.
  - FRAME: each accepted sample advances the index. An accepted sop restarts at index 0 (the old frame is abandoned with no eof). After index FRAME_LEN-1 is accepted -> IDLE.
- Classification by frame index k:
  - k < PREAMB_LEN: dropped.
  - Otherwise, with p = (k-PREAMB_LEN) mod PILOT_STEP: p==0 is a pilot and is dropped; else it is data.
  - Implement p with a wrap counter; no divider.
- Data samples are sliced and loaded into the output register on the accept edge. Latency: valid_out rises the cycle after acceptance. A simultaneous accept and downstream take is allowed, giving full throughput.
- Dropped samples never assert valid_out but still consume the handshake.
- 16-QAM Gray slicing, per axis, value v -> 2 bits:
  - v < -2·LEVEL -> 00
  - -2·LEVEL <= v < 0 -> 01
  - 0 <= v < 2·LEVEL -> 11
  - v >= 2·LEVEL -> 10
  - bits_out = {slice(I), slice(Q)}.
- QPSK: bits_out = {2'b00, I>=0, Q>=0}.
- Comparisons are signed at 17 bits to avoid overflow at 2·LEVEL.
- data_idx increments per emitted data carrier and resets to 0 at sop.
- eof = 1 with the data carrier at the last data index of the frame (k = FRAME_LEN-1, or the highest non-pilot k below it).

Optional Feature:
- Macro: DIST_ACC_EN.
- When defined, adds outputs dist_acc[23:0] and dist_valid.
  - For every data carrier, |I-Î|+|Q-Ŷ| is added to a saturating 24-bit accumulator, where Î and Ŷ are the sliced ideal levels.
  - At eof the accumulated value is output on dist_acc with a one-cycle dist_valid pulse, then the accumulator clears.
  - sop also clears the accumulator.
- When undefined, these ports and the logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset mid-frame: res=1 during FRAME -> next cycle valid_out=0, state IDLE; samples without sop after reset produce no output.
- Full 16-QAM frame, FRAME_LEN=1024, PREAMB_LEN=128, PILOT_STEP=8: expect exactly 784 valid_out beats. The first data carrier is k=129 and eof is at k=1023. I=24576, Q=-8192 -> bits_out=4'b1001.
- Thresholds, 16-QAM: I ∈ {-16385, -16384, -1, 0, 16383, 16384} -> I bits 00, 01, 01, 11, 11, 10.
- QPSK, mod_switch=0: I=-5, Q=7 -> bits_out=4'b0001; I=0, Q=0 -> 4'b0011.
- Backpressure: hold ready_in=0 for 5 cycles with valid_in=1 -> ready_out=0, bits_out stable, no sample lost. On release, emission continues in order with contiguous data_idx.
- sop restart at k=500: data_idx returns to 0, no eof for the abandoned frame. With DIST_ACC_EN and ideal points, dist_acc=0 at the next eof.
